// File: rtl/div8_seq.sv
// Sequential unsigned restoring divider: one shift-subtract step per clock, WIDTH steps per operation.
// Divide-by-zero answers in one cycle with quotient all ones, remainder = dividend and the flag set.
module div8_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t           state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [WIDTH-1:0] dvd, dvd_d;
  logic [WIDTH-1:0] dvs, dvs_d;
  logic [WIDTH:0]   part, part_d;
  logic [WIDTH-1:0] quotient_d, remainder_d;
  logic             done_d, dbz_d;

  logic [WIDTH:0]   shifted, trial, part_step;
  logic [WIDTH-1:0] dvd_step;
  logic             qbit;

  // Partial stays below the divisor, so the trial's top bit is a reliable sign.
  always_comb begin
    shifted   = {part[WIDTH-1:0], dvd[WIDTH-1]};
    trial     = shifted - {1'b0, dvs};
    qbit      = ~trial[WIDTH];
    part_step = qbit ? trial : shifted;
    dvd_step  = (dvd << 1) | {{(WIDTH-1){1'b0}}, qbit};
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    dvd_d       = dvd;
    dvs_d       = dvs;
    part_d      = part;
    quotient_d  = quotient;
    remainder_d = remainder;
    dbz_d       = div_by_zero;
    done_d      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            done_d      = 1'b1;
          end else begin
            dvd_d   = dividend;
            dvs_d   = divisor;
            part_d  = '0;
            cnt_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        part_d = part_step;
        dvd_d  = dvd_step;
        cnt_d  = cnt + 1'b1;
        if (cnt == LAST) begin
          quotient_d  = dvd_step;
          remainder_d = part_step[WIDTH-1:0];
          dbz_d       = 1'b0;
          done_d      = 1'b1;
          cnt_d       = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      part        <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      dvd         <= dvd_d;
      dvs         <= dvs_d;
      part        <= part_d;
      quotient    <= quotient_d;
      remainder   <= remainder_d;
      div_by_zero <= dbz_d;
      done        <= done_d;
    end
  end

  assign busy = (state == CALC);

endmodule

// File: tb/tb_div8_seq.sv
// Directed bench for div8_seq: hand-computed quotients/remainders, latency, busy width and reset abort.
module tb_div8_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient, remainder;

  int n_checks = 0;
  int n_fail = 0;

  div8_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one request at a negedge; returns at a negedge one cycle after the done cycle.
  task automatic do_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er, input logic ez,
                        input int exp_lat, input int inject_at);
    int k;
    int busy_cnt;
    logic [7:0] hold_q;
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0; dividend = ~a; divisor = 8'd3;
    @(negedge clk);
    k = 0; busy_cnt = 0;
    while (!done && k < 20) begin
      if (busy) busy_cnt++;
      if (k == inject_at) begin start = 1'b1; dividend = 8'd50; divisor = 8'd5; end
      if (k == inject_at + 1) start = 1'b0;
      @(negedge clk);
      k++;
    end
    check({tag, "_done_seen"}, done, 1);
    check({tag, "_latency"}, k, exp_lat);
    check({tag, "_busy_cycles"}, busy_cnt, exp_lat);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_quotient"}, quotient, eq);
    check({tag, "_remainder"}, remainder, er);
    check({tag, "_dbz"}, div_by_zero, ez);
    hold_q = quotient;
    @(negedge clk);
    check({tag, "_done_width"}, done, 0);
    check({tag, "_q_hold"}, quotient, hold_q);
  endtask

  initial begin
    int dcount;
    #2;
    check("reset_quotient", quotient, 0);
    check("reset_remainder", remainder, 0);
    check("reset_flags", {busy, done, div_by_zero}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_div("d200_7", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 8, -1);
    do_div("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 8, -1);
    do_div("d5_10", 8'd5, 8'd10, 8'd0, 8'd5, 1'b0, 8, -1);
    do_div("d0_3", 8'd0, 8'd3, 8'd0, 8'd0, 1'b0, 8, -1);
    do_div("d255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 8, -1);
    do_div("d128_2", 8'd128, 8'd2, 8'd64, 8'd0, 1'b0, 8, -1);
    do_div("d77_0", 8'd77, 8'd0, 8'hFF, 8'd77, 1'b1, 0, -1);
    do_div("d9_3", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 8, -1);

    // A second request mid-flight must be ignored; no extra done afterwards.
    do_div("d100_9_inj", 8'd100, 8'd9, 8'd11, 8'd1, 1'b0, 8, 3);
    dcount = 0;
    repeat (12) begin
      if (done) dcount++;
      @(negedge clk);
    end
    check("inject_extra_done", dcount, 0);
    check("inject_idle", busy, 0);

    // Start held high: completions 9 cycles apart, each done one cycle wide.
    start = 1'b1; dividend = 8'd100; divisor = 8'd9;
    @(posedge clk); #1;
    @(negedge clk);
    for (int c = 0; c <= 26; c++) begin
      check($sformatf("stream_done_c%0d", c), done, (c == 8 || c == 17 || c == 26) ? 1 : 0);
      if (done) begin
        check($sformatf("stream_q_c%0d", c), quotient, 11);
        check($sformatf("stream_r_c%0d", c), remainder, 1);
      end
      if (c == 9 || c == 18) check($sformatf("stream_busy_c%0d", c), busy, 1);
      if (c == 26) start = 1'b0;
      @(negedge clk);
    end
    check("stream_stop_idle", busy, 0);

    // Reset in the middle of a calculation aborts it.
    start = 1'b1; dividend = 8'd200; divisor = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    check("abort_flags", {busy, done, div_by_zero}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    repeat (12) begin
      if (done || busy) dcount++;
      @(negedge clk);
    end
    check("abort_no_done", dcount, 0);
    do_div("d200_7_after", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 8, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
